sys_mem: RTL and testbench

Single-port byte-wide RAM for the 6502 CPU system model. Clocked on the inverted CPU phase, so CPU address/data launched on one phi0 edge are sampled half a period later. Carries two test-only extensions: a whole-array bulk-load override and a continuous whole-array monitor. These let benches preload programs and compare contents against a reference model.

---
 rtl/sys_mem.sv | 50 +++++
 tb/tb_sys_mem.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sys_mem.sv
// sys_mem: single-port byte-wide RAM for the 6502 system model.
// The registered read returns the contents from before any same-edge write.
// Two test-only extensions are included:
//   - a whole-array bulk-load override;
//   - a continuous whole-array monitor.
module sys_mem #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [WIDTH-1:0]      din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      dout,
  input  logic                  override_mem,
  input  logic [WIDTH-1:0]      mem_override_in [DEPTH],
  output logic [WIDTH-1:0]      mem_monitor [DEPTH]
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;
  logic [IDX_W-1:0] idx;

  // Full-width range check: upper address bits never alias into the array.
  always_comb begin
    in_range = (32'(addr) < 32'(DEPTH));
    idx      = addr[IDX_W-1:0];
  end

  // Priority per edge: reset, then bulk override, then normal write/read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      dout <= '0;
    end else if (override_mem) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= mem_override_in[i];
      dout <= in_range ? mem_override_in[idx] : '0;
    end else begin
      if (we && in_range) mem[idx] <= din;
      dout <= in_range ? mem[idx] : '0;
    end
  end

  assign mem_monitor = mem;

endmodule

// File: tb/tb_sys_mem.sv
// tb_sys_mem: directed and random checks of sys_mem against a reference array.
module tb_sys_mem;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DEPTH      = 1024;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  we = 1'b0;
  logic [WIDTH-1:0]      din = '0;
  logic [ADDR_WIDTH-1:0] addr = '0;
  logic [WIDTH-1:0]      dout;
  logic                  override_mem = 1'b0;
  logic [WIDTH-1:0]      ovr [DEPTH];
  logic [WIDTH-1:0]      mon [DEPTH];

  logic [WIDTH-1:0]      ref_mem [DEPTH];
  int                    checks = 0;
  int                    fails  = 0;

  sys_mem #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .din(din),
    .addr(addr),
    .dout(dout),
    .override_mem(override_mem),
    .mem_override_in(ovr),
    .mem_monitor(mon)
  );

  always #5 clk = ~clk;

  // One clock: drive on negedge, predict from the model, check dout after posedge.
  task automatic cycle(input logic r, input logic ov, input logic w,
                       input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                       input string tag);
    logic [WIDTH-1:0] exp;
    bit inr;
    @(negedge clk);
    reset = r; override_mem = ov; we = w; addr = a; din = d;
    inr = int'(a) < int'(DEPTH);
    if (r) begin
      exp = '0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (ov) begin
      exp = inr ? ovr[int'(a)] : '0;
      foreach (ref_mem[i]) ref_mem[i] = ovr[i];
    end else begin
      exp = inr ? ref_mem[int'(a)] : '0;
      if (w && inr) ref_mem[int'(a)] = d;
    end
    @(posedge clk);
    #1;
    checks++;
    assert (dout === exp) else begin
      fails++;
      $error("FAIL %s: dout=%h expected=%h", tag, dout, exp);
    end
  endtask

  // Compare every monitor entry with the model; the count of bad entries must be zero.
  task automatic check_monitor(input string tag);
    int bad = 0;
    int first = -1;
    foreach (mon[i]) if (mon[i] !== ref_mem[i]) begin
      bad++;
      if (first < 0) first = i;
    end
    checks++;
    assert (bad === 0) else begin
      fails++;
      $error("FAIL %s: %0d mismatching entries (first %0d: got %h expected %h), expected 0",
             tag, bad, first, mon[first], ref_mem[first]);
    end
  endtask

  task automatic check_word(input string tag, input int i, input logic [WIDTH-1:0] exp);
    checks++;
    assert (mon[i] === exp) else begin
      fails++;
      $error("FAIL %s: mon[%0d]=%h expected=%h", tag, i, mon[i], exp);
    end
  endtask

  initial begin
    foreach (ovr[i]) ovr[i] = '0;
    foreach (ref_mem[i]) ref_mem[i] = 'x;

    // Reset state.
    cycle(1, 0, 0, 16'h0000, 8'h00, "reset_dout");
    check_monitor("reset_mon");

    // Preload 0xA5 everywhere, then reset clears it.
    foreach (ovr[i]) ovr[i] = 8'hA5;
    cycle(0, 1, 0, 16'h0007, 8'h00, "ovr_a5_dout");
    check_monitor("ovr_a5_mon");
    cycle(1, 0, 0, 16'h0007, 8'h00, "reset_clear_dout");
    check_monitor("reset_clear_mon");

    // Basic write then read.
    cycle(0, 0, 1, 16'h0000, 8'h4A, "wr0");
    cycle(0, 0, 1, 16'h0010, 8'h3C, "wr10");
    cycle(0, 0, 0, 16'h0000, 8'h00, "rd0");
    cycle(0, 0, 0, 16'h0010, 8'h00, "rd10");
    check_word("mon0", 0, 8'h4A);

    // Read-before-write at location 5.
    cycle(0, 0, 1, 16'h0005, 8'h11, "rbw_init");
    cycle(0, 0, 1, 16'h0005, 8'h22, "rbw_old");
    cycle(0, 0, 0, 16'h0005, 8'h00, "rbw_new");

    // Override with a write attempted on the same edge.
    foreach (ovr[i]) ovr[i] = 8'(i);
    cycle(0, 1, 1, 16'h0003, 8'hFF, "ovr_idx_dout");
    check_word("ovr_mon3", 3, 8'h03);
    check_monitor("ovr_idx_mon");
    cycle(0, 0, 0, 16'h0003, 8'h00, "ovr_release_rd");

    // Out-of-range writes and reads, including an aliasing candidate.
    cycle(0, 0, 1, 16'h0400, 8'h77, "oor_wr");
    cycle(0, 0, 1, 16'h8400, 8'h66, "oor_wr_alias");
    check_monitor("oor_mon");
    cycle(0, 0, 0, 16'h0400, 8'h00, "oor_rd");
    cycle(0, 0, 0, 16'hFFFF, 8'h00, "oor_rd_top");
    cycle(0, 0, 1, 16'h03FF, 8'h5D, "last_wr");
    cycle(0, 0, 0, 16'h03FF, 8'h00, "last_rd");
    check_word("last_mon", DEPTH - 1, 8'h5D);

    // Reset dominates a simultaneous override and write.
    cycle(1, 1, 1, 16'h0003, 8'hEE, "reset_over_all");
    check_monitor("reset_over_all_mon");

    // Random regression.
    for (int n = 0; n < 1000; n++) begin
      logic [ADDR_WIDTH-1:0] a;
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 31));
      else a = 16'($urandom_range(DEPTH - 16, DEPTH + 15));
      cycle(0, 0, 1'($urandom), a, 8'($urandom), "rand");
    end
    check_monitor("rand_final_mon");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
